// File: rtl/mitchell_lut_arbiter.sv
// rtl/mitchell_lut_arbiter.sv - round-robin arbiter sharing one external Mitchell_lut among NREQ requesters
// Optional macro MITCHELL_ARB_SETTLE2_EN adds a second settle cycle before the result is captured.
module mitchell_lut_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 7,
  parameter int CW   = 10,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_a,
  input  logic [NREQ*AW-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [AW-1:0]        lut_a,
  output logic [AW-1:0]        lut_b,
  input  logic [CW-1:0]        lut_c,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IW-1:0]        rsp_id,
  output logic [CW-1:0]        rsp_c,
  output logic                 busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETTLE  = 2'd1;
  localparam logic [1:0] RESP    = 2'd2;
`ifdef MITCHELL_ARB_SETTLE2_EN
  localparam logic [1:0] SETTLE2 = 2'd3;
`endif

  localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

  logic [1:0]    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] grant;
  logic [IW:0]   cand;
  logic          found;

  // First valid requester after ptr, wrapping modulo NREQ.
  always_comb begin
    grant = ptr;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = {1'b0, ptr} + (IW+1)'(i);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!found && req_valid[cand[IW-1:0]]) begin
        grant = cand[IW-1:0];
        found = 1'b1;
      end
    end
  end

  assign req_ready = (!rst && state == IDLE && |req_valid) ? (NREQ'(1) << grant) : '0;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= IW'(NREQ - 1);
      lut_a  <= '0;
      lut_b  <= '0;
      rsp_id <= '0;
      rsp_c  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            lut_a  <= req_a[int'(grant)*AW +: AW];
            lut_b  <= req_b[int'(grant)*AW +: AW];
            rsp_id <= grant;
            ptr    <= grant;
            state  <= SETTLE;
          end
        end
        SETTLE: begin
`ifdef MITCHELL_ARB_SETTLE2_EN
          state <= SETTLE2;
`else
          rsp_c <= lut_c;
          state <= RESP;
`endif
        end
`ifdef MITCHELL_ARB_SETTLE2_EN
        SETTLE2: begin
          rsp_c <= lut_c;
          state <= RESP;
        end
`endif
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mitchell_lut_arbiter.sv
// tb/tb_mitchell_lut_arbiter.sv - directed bench for mitchell_lut_arbiter with a Mitchell product lut model
module tb_mitchell_lut_arbiter;

`ifdef MITCHELL_ARB_SETTLE2_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [27:0] req_a;
  logic [27:0] req_b;
  logic [3:0]  req_ready;
  logic [6:0]  lut_a;
  logic [6:0]  lut_b;
  logic [9:0]  lut_c;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [9:0]  rsp_c;
  logic        busy;

  logic        force_en;
  logic [9:0]  force_val;
  int          checks;
  int          errors;

  int exp_g[5]     = '{0, 1, 2, 3, 0};
  int sweep_exp[8] = '{0, 16, 64, 128, 256, 384, 512, 768};

  mitchell_lut_arbiter #(.NREQ(4), .AW(7), .CW(10)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .lut_a(lut_a), .lut_b(lut_b), .lut_c(lut_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_c(rsp_c),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mitchell log-domain product of two 7-bit operands, scaled down by 16.
  function automatic logic [9:0] mitchell(input logic [6:0] a, input logic [6:0] b);
    int k1, k2, f1, f2, s, p;
    if (a == 0 || b == 0) return 10'd0;
    k1 = 0;
    k2 = 0;
    for (int i = 0; i < 7; i++) begin
      if (a[i]) k1 = i;
      if (b[i]) k2 = i;
    end
    f1 = int'(a) - (1 << k1);
    f2 = int'(b) - (1 << k2);
    s  = (f1 << k2) + (f2 << k1);
    if (s >= (1 << (k1 + k2))) p = 2 * s;
    else p = (1 << (k1 + k2)) + s;
    return 10'(p >> 4);
  endfunction

  always_comb lut_c = force_en ? force_val : mitchell(lut_a, lut_b);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if ({lut_a, lut_b} !== 14'd0) begin errors++; $display("FAIL reset_lut_ab got %h %h exp 0 0", lut_a, lut_b); end
    checks++; if ({rsp_id, rsp_c} !== 12'd0) begin errors++; $display("FAIL reset_rsp got %h %h exp 0 0", rsp_id, rsp_c); end
    step();
    checks++; if (busy !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("FAIL reset_hold got busy %b ready %b exp 0 0000", busy, req_ready); end
    rst = 1'b0;
    req_valid = 4'b0000;
  endtask

  task automatic test_single();
    req_a[6:0] = 7'd16;
    req_b[6:0] = 7'd32;
    req_valid  = 4'b0001;
    force_en   = 1'b1;
    force_val  = 10'h155;
    rsp_ready  = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b exp 0001", req_ready); end
    step();
    req_valid = 4'b0000;
    checks++; if (lut_a !== 7'd16 || lut_b !== 7'd32) begin errors++; $display("FAIL single_lut got %0d %0d exp 16 32", lut_a, lut_b); end
    checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL single_settle got busy %b rsp_valid %b exp 1 0", busy, rsp_valid); end
    repeat (LAT - 1) step();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_c !== 10'h155) begin
      errors++; $display("FAIL single_rsp got v %b id %0d c %h exp 1 0 155", rsp_valid, rsp_id, rsp_c); end
    step();
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_done got v %b busy %b exp 0 0", rsp_valid, busy); end
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    force_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req_a[k*7 +: 7] = 7'(10 + k);
      req_b[k*7 +: 7] = 7'(20 + k);
    end
    req_valid = 4'b1111;
    #1;
    for (int t = 0; t < 5; t++) begin
      checks++; if (req_ready !== 4'(1 << exp_g[t])) begin
        errors++; $display("FAIL rr_grant[%0d] got %b exp %b", t, req_ready, 4'(1 << exp_g[t])); end
      step();
      checks++; if (lut_a !== 7'(10 + exp_g[t]) || lut_b !== 7'(20 + exp_g[t])) begin
        errors++; $display("FAIL rr_lut[%0d] got %0d %0d exp %0d %0d", t, lut_a, lut_b, 10 + exp_g[t], 20 + exp_g[t]); end
      repeat (LAT - 1) begin
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rr_ready_busy got %b exp 0000", req_ready); end
        step();
      end
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_g[t]) || req_ready !== 4'b0000) begin
        errors++; $display("FAIL rr_rsp[%0d] got v %b id %0d ready %b exp 1 %0d 0000", t, rsp_valid, rsp_id, req_ready, exp_g[t]); end
      step();
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_backpressure();
    req_a[21 +: 7] = 7'd5;
    req_valid = 4'b1000;
    force_en  = 1'b1;
    force_val = 10'h2AA;
    rsp_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_grant got %b exp 1000", req_ready); end
    step();
    req_valid = 4'b1111;
    repeat (LAT - 1) step();
    force_val = 10'h0F0;
    for (int c = 0; c < 5; c++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_c !== 10'h2AA || rsp_id !== 2'd3) begin
        errors++; $display("FAIL bp_hold[%0d] got v %b c %h id %0d exp 1 2aa 3", c, rsp_valid, rsp_c, rsp_id); end
      checks++; if (req_ready !== 4'b0000 || busy !== 1'b1) begin
        errors++; $display("FAIL bp_busy[%0d] got ready %b busy %b exp 0000 1", c, req_ready, busy); end
      step();
    end
    rsp_ready = 1'b1;
    step();
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release got busy %b v %b exp 0 0", busy, rsp_valid); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_next_grant got %b exp 0001", req_ready); end
    req_valid = 4'b0000;
    force_en  = 1'b0;
  endtask

  task automatic test_reset_mid();
    req_a[7 +: 7] = 7'd33;
    req_b[7 +: 7] = 7'd44;
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rm_grant got %b exp 0010", req_ready); end
    step();
    req_valid = 4'b0000;
    checks++; if (busy !== 1'b1 || lut_a !== 7'd33) begin errors++; $display("FAIL rm_settle got busy %b lut_a %0d exp 1 33", busy, lut_a); end
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
      errors++; $display("FAIL rm_async got busy %b v %b ready %b exp 0 0 0000", busy, rsp_valid, req_ready); end
    checks++; if ({lut_a, lut_b} !== 14'd0 || {rsp_id, rsp_c} !== 12'd0) begin
      errors++; $display("FAIL rm_clear got %h %h %h %h exp all 0", lut_a, lut_b, rsp_id, rsp_c); end
    step();
    rst = 1'b0;
    for (int c = 0; c < LAT + 2; c++) begin
      step();
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL rm_no_rsp[%0d] got v %b busy %b exp 0 0", c, rsp_valid, busy); end
    end
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rm_first_grant got %b exp 0001", req_ready); end
    step();
    req_valid = 4'b0000;
    checks++; if (lut_a !== 7'd10) begin errors++; $display("FAIL rm_lut got %0d exp 10", lut_a); end
    repeat (LAT - 1) step();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin errors++; $display("FAIL rm_rsp got v %b id %0d exp 1 0", rsp_valid, rsp_id); end
    step();
  endtask

  task automatic test_lone();
    req_valid = 4'b0100;
    for (int t = 0; t < 3; t++) begin
      req_a[14 +: 7] = 7'(40 + t);
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL lone_grant[%0d] got %b exp 0100", t, req_ready); end
      step();
      checks++; if (lut_a !== 7'(40 + t)) begin errors++; $display("FAIL lone_lut[%0d] got %0d exp %0d", t, lut_a, 40 + t); end
      repeat (LAT - 1) begin
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL lone_busy[%0d] got %b exp 0000", t, req_ready); end
        step();
      end
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin
        errors++; $display("FAIL lone_rsp[%0d] got v %b id %0d exp 1 2", t, rsp_valid, rsp_id); end
      step();
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_sweep();
    force_en = 1'b0;
    for (int m = 0; m < 8; m++) begin
      req_a[7 +: 7] = 7'(16 * m);
      req_b[7 +: 7] = 7'(16 * m);
      req_valid = 4'b0010;
      step();
      req_valid = 4'b0000;
      repeat (LAT - 1) step();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_c !== 10'(sweep_exp[m])) begin
        errors++; $display("FAIL sweep[%0d] got v %b id %0d c %0d exp 1 1 %0d", m, rsp_valid, rsp_id, rsp_c, sweep_exp[m]); end
      step();
      checks++; if (lut_a !== 7'(16 * m) || lut_b !== 7'(16 * m)) begin
        errors++; $display("FAIL sweep_hold[%0d] got %0d %0d exp %0d", m, lut_a, lut_b, 16 * m); end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    force_en  = 1'b0;
    force_val = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_lone();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mitchell_lut_arbiter.md
MITCHELL_LUT_ARBITER -- requirements
Module: mitchell_lut_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters sharing one Mitchell_lut instance.
REQ-002 The block SHALL have parameter AW, default 7, giving the operand width; it matches the lut a/b ports.
REQ-003 The block SHALL have parameter CW, default 10, giving the result width; it matches the lut c port.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port req_valid, input, NREQ bits: per-requester operand valid.
REQ-007 The block SHALL have port req_a, input, NREQ*AW bits: packed operand a; requester k occupies bits [k*AW +: AW].
REQ-008 The block SHALL have port req_b, input, NREQ*AW bits: packed operand b, packed the same way as req_a.
REQ-009 The block SHALL have port req_ready, output, NREQ bits: one-hot accept strobe.
REQ-010 The block SHALL have ports lut_a and lut_b, outputs, AW bits each: registered operands driven to the external Mitchell_lut.
REQ-011 The block SHALL have port lut_c, input, CW bits: combinational result returned by the Mitchell_lut.
REQ-012 The block SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_id (output, clog2(NREQ)) and rsp_c (output, CW): the response channel.
REQ-013 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, SETTLE and RESP, plus SETTLE2 when the configuration macro is defined.
REQ-015 In IDLE, when any req_valid bit is high, the block SHALL select a grant g by round-robin, searching from ptr+1 upward modulo NREQ.
REQ-016 In that same IDLE cycle, the block SHALL assert req_ready[g] combinationally; the transfer occurs when req_valid[g] and req_ready[g] are both high.
REQ-017 On the transfer edge, the block SHALL load lut_a, lut_b and rsp_id from requester g, set ptr to g, and move to SETTLE.
REQ-018 req_ready SHALL be all-zero in every state except IDLE, and at most one bit of req_ready SHALL ever be high.
REQ-019 In SETTLE, the block SHALL capture lut_c into rsp_c and move to RESP, or to SETTLE2 when the macro is defined.
REQ-020 In RESP, rsp_valid SHALL be 1, and rsp_c and rsp_id SHALL hold stable until rsp_ready is high.
REQ-021 On the edge where rsp_valid and rsp_ready are both high, the block SHALL clear rsp_valid and return to IDLE.
REQ-022 A new grant SHALL NOT be issued in the same cycle as a response handshake; the minimum issue interval is 3 cycles, or 4 with the macro.
REQ-023 lut_a and lut_b SHALL hold their last operands until the next grant.
REQ-024 Requests arriving while the block is not in IDLE SHALL wait; the block never drops or reorders an accepted request.
REQ-025 When only requester k is valid, k SHALL be granted regardless of ptr.
REQ-026 ptr SHALL wrap from NREQ-1 to 0.

Reset
REQ-027 While rst is high, the block SHALL force: state IDLE, ptr=NREQ-1 (so requester 0 has first priority), req_ready=0, lut_a=0, lut_b=0, rsp_valid=0, rsp_id=0, rsp_c=0, busy=0.
REQ-028 A reset asserted mid-transaction SHALL discard the in-flight operation; no rsp_valid is produced for it after reset deasserts.
REQ-029 After reset deasserts, the block SHALL accept requests starting on the first rising clock edge.

Configuration
REQ-030 When macro MITCHELL_ARB_SETTLE2_EN is defined, the block SHALL insert state SETTLE2 between SETTLE and RESP.
REQ-031 With MITCHELL_ARB_SETTLE2_EN defined, rsp_c SHALL be captured from lut_c at the exit of SETTLE2, giving the lut two full cycles to settle and a grant-to-rsp_valid latency of 3 edges.
REQ-032 Without MITCHELL_ARB_SETTLE2_EN, SETTLE2 SHALL be absent and the grant-to-rsp_valid latency is 2 edges.

Verification
REQ-033 Single request: req 0 valid with a=16, b=32, bench lut model returns 10'h155, rsp_ready=1 -> lut_a=16 and lut_b=32 one edge after the grant; rsp_valid with rsp_id=0 and rsp_c=10'h155 after 2 edges (3 with the macro).
REQ-034 All four requesters held valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; each rsp_id matches its grant; req_ready is never more than one-hot.
REQ-035 Backpressure: rsp_ready=0 for 5 cycles during RESP -> rsp_valid, rsp_c and rsp_id stay stable, req_ready stays 0, busy=1; release -> IDLE on the next edge.
REQ-036 Reset mid-transaction: rst asserted in SETTLE -> all outputs return to their reset values immediately; no response appears after release; the next grant goes to requester 0.
REQ-037 Lone requester: only req 2 valid, repeated 3 times -> all three grants go to 2 with no idle bubbles beyond the fixed interval.
REQ-038 Operand sweep: a and b stepping 0,16,...,112 from req 1 -> each rsp_c equals the Mitchell_lut golden value for that pair.
